compare_accumulator: RTL and testbench
======================================

COMPARE_ACCUMULATOR -- requirements
Module: compare_accumulator

Interface
REQ-001 Parameter: CNT_W, 8, width of each outcome counter; legal range 2..16.
REQ-002 Port: clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port: rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port: in_valid, input, 1, upstream sample available.
REQ-005 Port: in_ready, output, 1, block can accept a sample this cycle.
REQ-006 Port: Data_in_A, input, 4, operand A presented to the upstream comparator.
REQ-007 Port: Data_in_B, input, 4, operand B presented to the upstream comparator.
REQ-008 Port: less / equal / greater, input, 1 each, comparator flags for the same A and B.
REQ-009 Port: clr, input, 1, synchronous clear of the counters and the streak.
REQ-010 Port: out_valid, output, 1, result register holds an unconsumed result.
REQ-011 Port: out_ready, input, 1, downstream accepts the result.
REQ-012 Port: out_code, output, 2, outcome code: 00 less, 01 equal, 10 greater.
REQ-013 Port: out_max, output, 4, the larger of A and B; equals A when A equals B.
REQ-014 Port: cnt_less / cnt_equal / cnt_greater, output, CNT_W each, running outcome counts.
REQ-015 Port: streak, output, 4, number of consecutive identical outcomes, including the current one.
REQ-016 Port: flag_err, output, 1, sticky error for illegal flag combinations (see Configuration).

Function
REQ-017 The block SHALL implement a two-state FSM with states IDLE and HOLD.
REQ-018 In IDLE: in_ready=1 and out_valid=0.
REQ-019 In HOLD: in_ready=0 and out_valid=1.
REQ-020 An accept SHALL occur when in_valid=1 in IDLE.
REQ-021 On an accept, the block SHALL register the sample, update the counters and streak, and move to HOLD; the result is visible one cycle after the accept.
REQ-022 In HOLD, out_valid=1 and out_ready=1 SHALL return the FSM to IDLE.
REQ-023 The earliest next accept SHALL be the cycle after the return to IDLE, giving a maximum throughput of one sample per 2 cycles.
REQ-024 While out_valid=1 and out_ready=0, out_code, out_max and all counters SHALL stay stable.
REQ-025 On an accept, the outcome counter for the decoded code SHALL increment by 1 and saturate at 2^CNT_W-1; the other counters SHALL hold.
REQ-026 streak SHALL be set to 1 when the new code differs from the previous accepted code, or on the first accept after reset or clr.
REQ-027 Otherwise streak SHALL increment and saturate at 15.
REQ-028 When clr=1 without an accept, all counters and streak SHALL go to 0; the FSM and result registers are unaffected.
REQ-029 When clr=1 coincides with an accept, the counters SHALL reflect only the new sample: the decoded counter is 1, the others 0, and streak is 1.
REQ-030 in_valid in HOLD SHALL be ignored; the sample is not captured.

Reset
REQ-031 While rst=1, the block SHALL immediately, independent of clk, force: state IDLE, in_ready=1, out_valid=0, out_code=00, out_max=0, all counters 0, streak 0, flag_err 0.
REQ-032 A reset asserted in HOLD SHALL discard the pending result.
REQ-033 After rst deasserts, the first accept SHALL be treated as the first sample, so streak becomes 1.

Configuration
REQ-034 Macro CMP_ONEHOT_CHECK_EN defined: an accept whose flags are not exactly one-hot SHALL set flag_err=1, sticky until rst.
REQ-035 With CMP_ONEHOT_CHECK_EN defined, such a sample SHALL still go to HOLD with out_code=11 and out_max=0, and SHALL leave the counters and streak unchanged.
REQ-036 Macro CMP_ONEHOT_CHECK_EN not defined: flag_err SHALL be tied to 0, and the flags SHALL be decoded with priority greater > equal > less.
REQ-037 With CMP_ONEHOT_CHECK_EN not defined, all flags zero SHALL decode as less.

Verification
REQ-038 Reset, then accept A=10, B=12, less=1 -> next cycle out_valid=1, out_code=00, out_max=12, cnt_less=1, streak=1.
REQ-039 Accept A=15/B=11 greater, then A=10/B=10 equal, then A=9/B=9 equal -> final out_code=01, out_max=9, cnt_greater=1, cnt_equal=2, streak=2.
REQ-040 Hold out_ready=0 for 5 cycles with in_valid=1 and new data -> outputs stable and in_ready=0; after out_ready=1, one cycle later in_ready=1.
REQ-041 With CNT_W=2, accept 5 less samples -> cnt_less=3; with 17 identical samples -> streak=15.
REQ-042 Assert clr in the same cycle as accepting a greater sample, with cnt_less=2 beforehand -> cnt_greater=1, cnt_less=0, streak=1.
REQ-043 With CMP_ONEHOT_CHECK_EN defined, accept less=1 and greater=1 -> out_code=11, flag_err=1, counters unchanged; rst mid-HOLD -> out_valid=0 and flag_err=0 immediately.

Source files
------------

// File: rtl/compare_accumulator.sv
// Compare accumulator: registers comparator results behind a valid/ready handshake and keeps outcome counts and a streak.
// Optional CMP_ONEHOT_CHECK_EN: reject flag sets that are not one-hot (sticky flag_err) instead of priority decoding.
module compare_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       Data_in_A,
  input  logic [3:0]       Data_in_B,
  input  logic             less,
  input  logic             equal,
  input  logic             greater,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_code,
  output logic [3:0]       out_max,
  output logic [CNT_W-1:0] cnt_less,
  output logic [CNT_W-1:0] cnt_equal,
  output logic [CNT_W-1:0] cnt_greater,
  output logic [3:0]       streak,
  output logic             flag_err
);

  typedef enum logic {IDLE, HOLD} state_t;
  typedef enum logic [1:0] {
    CODE_LESS    = 2'b00,
    CODE_EQUAL   = 2'b01,
    CODE_GREATER = 2'b10,
    CODE_ERR     = 2'b11
  } code_t;

  state_t           state, state_nxt;
  logic             accept;
  code_t            sample_code, last_code, last_code_nxt;
  logic             sample_bad;
  logic [3:0]       sample_max;
  logic [CNT_W-1:0] cnt_less_nxt, cnt_equal_nxt, cnt_greater_nxt;
  logic [3:0]       streak_nxt;

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    sample_code = CODE_LESS;
    sample_bad  = 1'b0;
`ifdef CMP_ONEHOT_CHECK_EN
    case ({greater, equal, less})
      3'b001:  sample_code = CODE_LESS;
      3'b010:  sample_code = CODE_EQUAL;
      3'b100:  sample_code = CODE_GREATER;
      default: begin
        sample_code = CODE_ERR;
        sample_bad  = 1'b1;
      end
    endcase
`else
    // Priority decode; a sample with no flag set counts as less.
    if (greater)    sample_code = CODE_GREATER;
    else if (equal) sample_code = CODE_EQUAL;
    else            sample_code = CODE_LESS;
`endif
    sample_max = sample_bad ? 4'd0 : ((Data_in_A >= Data_in_B) ? Data_in_A : Data_in_B);
  end

  // clr zeroes first, so a coinciding accept counts on top of an empty history.
  always_comb begin
    cnt_less_nxt    = cnt_less;
    cnt_equal_nxt   = cnt_equal;
    cnt_greater_nxt = cnt_greater;
    streak_nxt      = streak;
    last_code_nxt   = last_code;
    if (clr) begin
      cnt_less_nxt    = '0;
      cnt_equal_nxt   = '0;
      cnt_greater_nxt = '0;
      streak_nxt      = '0;
    end
    if (accept && !sample_bad) begin
      case (sample_code)
        CODE_EQUAL:   cnt_equal_nxt   = cnt_inc(cnt_equal_nxt);
        CODE_GREATER: cnt_greater_nxt = cnt_inc(cnt_greater_nxt);
        default:      cnt_less_nxt    = cnt_inc(cnt_less_nxt);
      endcase
      // A zero streak only exists before the first accept since reset/clr.
      if (streak_nxt == 4'd0 || sample_code != last_code) streak_nxt = 4'd1;
      else if (streak_nxt != 4'd15)                       streak_nxt = streak_nxt + 4'd1;
      last_code_nxt = sample_code;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      out_code    <= 2'b00;
      out_max     <= 4'd0;
      cnt_less    <= '0;
      cnt_equal   <= '0;
      cnt_greater <= '0;
      streak      <= 4'd0;
      last_code   <= CODE_LESS;
    end else begin
      state       <= state_nxt;
      cnt_less    <= cnt_less_nxt;
      cnt_equal   <= cnt_equal_nxt;
      cnt_greater <= cnt_greater_nxt;
      streak      <= streak_nxt;
      last_code   <= last_code_nxt;
      if (accept) begin
        out_code <= sample_code;
        out_max  <= sample_max;
      end
    end
  end

`ifdef CMP_ONEHOT_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     flag_err <= 1'b0;
    else if (accept && sample_bad) flag_err <= 1'b1;
  end
`else
  assign flag_err = 1'b0;
`endif

endmodule

// File: tb/tb_compare_accumulator.sv
// Bench for compare_accumulator: a history-based reference model checked every cycle, plus literal scenario checks.
module tb_compare_accumulator;
  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, clr, out_ready;
  logic [3:0] a, b;
  logic       lf, ef, gf;

  logic       rdy8, vld8, err8, rdy2, vld2, err2;
  logic [1:0] code8, code2;
  logic [3:0] max8, max2, stk8, stk2;
  logic [7:0] cl8, ce8, cg8;
  logic [1:0] cl2, ce2, cg2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  compare_accumulator #(.CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8),
    .Data_in_A(a), .Data_in_B(b), .less(lf), .equal(ef), .greater(gf), .clr(clr),
    .out_valid(vld8), .out_ready(out_ready), .out_code(code8), .out_max(max8),
    .cnt_less(cl8), .cnt_equal(ce8), .cnt_greater(cg8), .streak(stk8), .flag_err(err8));

  compare_accumulator #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .Data_in_A(a), .Data_in_B(b), .less(lf), .equal(ef), .greater(gf), .clr(clr),
    .out_valid(vld2), .out_ready(out_ready), .out_code(code2), .out_max(max2),
    .cnt_less(cl2), .cnt_equal(ce2), .cnt_greater(cg2), .streak(stk2), .flag_err(err2));

  // Reference model: the list of accepted outcome codes since the last reset/clr.
  int hist[$];
  bit m_hold;
  int m_code, m_max;
  bit m_err;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_decode(input bit l, input bit e, input bit g);
`ifdef CMP_ONEHOT_CHECK_EN
    if (int'(l) + int'(e) + int'(g) != 1) return 3;
`endif
    if (g) return 2;
    if (e) return 1;
    return 0;
  endfunction

  function automatic int m_cnt(input int k, input int w);
    int n = 0;
    int lim = (1 << w) - 1;
    foreach (hist[i]) if (hist[i] == k) n++;
    return (n > lim) ? lim : n;
  endfunction

  function automatic int m_streak();
    int n = 0;
    if (hist.size() == 0) return 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != hist[hist.size()-1]) break;
      n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_hold = 1'b0;
    m_code = 0;
    m_max  = 0;
    m_err  = 1'b0;
  endtask

  task automatic model_update();
    int c;
    if (!m_hold && in_valid) begin
      c = m_decode(lf, ef, gf);
      if (clr) hist.delete();
      if (c == 3) m_err = 1'b1;
      else        hist.push_back(c);
      m_code = c;
      m_max  = (c == 3) ? 0 : ((a >= b) ? int'(a) : int'(b));
      m_hold = 1'b1;
    end else begin
      if (clr) hist.delete();
      if (m_hold && out_ready) m_hold = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready",     int'(rdy8),  int'(!m_hold));
      check("out_valid",    int'(vld8),  int'(m_hold));
      check("out_code",     int'(code8), m_code);
      check("out_max",      int'(max8),  m_max);
      check("cnt_less",     int'(cl8),   m_cnt(0, 8));
      check("cnt_equal",    int'(ce8),   m_cnt(1, 8));
      check("cnt_greater",  int'(cg8),   m_cnt(2, 8));
      check("streak",       int'(stk8),  m_streak());
      check("flag_err",     int'(err8),  int'(m_err));
      check("w2_in_ready",  int'(rdy2),  int'(!m_hold));
      check("w2_out_code",  int'(code2), m_code);
      check("w2_cnt_less",  int'(cl2),   m_cnt(0, 2));
      check("w2_cnt_equal", int'(ce2),   m_cnt(1, 2));
      check("w2_cnt_greater", int'(cg2), m_cnt(2, 2));
      check("w2_streak",    int'(stk2),  m_streak());
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Returns with the new result held (out_ready low) so callers can inspect it.
  task automatic send(input logic [3:0] da, input logic [3:0] db,
                      input bit l, input bit e, input bit g, input bit c);
    if (m_hold) begin
      out_ready = 1'b1;
      step();
    end
    in_valid = 1'b1; a = da; b = db; lf = l; ef = e; gf = g; clr = c; out_ready = 1'b0;
    step();
    in_valid = 1'b0; clr = 1'b0;
  endtask

  // Reset asserted between clock edges; outputs must change before any edge.
  task automatic do_reset();
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    check("async_out_valid", int'(vld8), 0);
    check("async_in_ready",  int'(rdy8), 1);
    check("async_cnt_less",  int'(cl8),  0);
    check("async_streak",    int'(stk8), 0);
    check("async_flag_err",  int'(err8), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0] h_code;
    logic [3:0] h_max;
    logic [7:0] h_cnt;
    rst = 1'b1; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; lf = 1'b0; ef = 1'b0; gf = 1'b0;
    model_reset();
    #1;
    check("rst_in_ready", int'(rdy8), 1);
    check("rst_out_valid", int'(vld8), 0);
    check("rst_out_code", int'(code8), 0);
    check("rst_out_max", int'(max8), 0);
    check("rst_counts", int'(cl8) + int'(ce8) + int'(cg8), 0);
    check("rst_streak", int'(stk8), 0);
    check("rst_flag_err", int'(err8), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // First sample after reset.
    send(4'd10, 4'd12, 1, 0, 0, 0);
    check("first_valid", int'(vld8), 1);
    check("first_code", int'(code8), 0);
    check("first_max", int'(max8), 12);
    check("first_cnt_less", int'(cl8), 1);
    check("first_streak", int'(stk8), 1);

    // Reset while a result is pending discards it.
    do_reset();

    send(4'd15, 4'd11, 0, 0, 1, 0);
    send(4'd10, 4'd10, 0, 1, 0, 0);
    send(4'd9,  4'd9,  0, 1, 0, 0);
    check("seq_code", int'(code8), 1);
    check("seq_max", int'(max8), 9);
    check("seq_cnt_greater", int'(cg8), 1);
    check("seq_cnt_equal", int'(ce8), 2);
    check("seq_streak", int'(stk8), 2);

    // Backpressure: new samples offered while held must be ignored.
    send(4'd2, 4'd6, 1, 0, 0, 0);
    h_code = code8; h_max = max8; h_cnt = cl8;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 4'($urandom); b = 4'($urandom); lf = 0; ef = 0; gf = 1;
      step();
      check("bp_in_ready", int'(rdy8), 0);
      check("bp_code", int'(code8), int'(h_code));
      check("bp_max", int'(max8), 6);
      check("bp_cnt_less", int'(cl8), int'(h_cnt));
    end
    check("bp_max_held", int'(h_max), 6);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("bp_release_ready", int'(rdy8), 1);
    out_ready = 1'b0;

    // Saturation of a 2-bit counter and of the streak.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(4'd3, 4'd7, 1, 0, 0, 0);
      if (i == 4) begin
        check("sat5_w2_cnt_less", int'(cl2), 3);
        check("sat5_w8_cnt_less", int'(cl8), 5);
      end
    end
    check("sat_w2_streak", int'(stk2), 15);
    check("sat_w8_streak", int'(stk8), 15);
    check("sat_w8_cnt_less", int'(cl8), 17);

    // clr coinciding with an accept.
    do_reset();
    send(4'd1, 4'd2, 1, 0, 0, 0);
    send(4'd1, 4'd2, 1, 0, 0, 0);
    check("pre_clr_cnt_less", int'(cl8), 2);
    send(4'd8, 4'd5, 0, 0, 1, 1);
    check("clracc_cnt_greater", int'(cg8), 1);
    check("clracc_cnt_less", int'(cl8), 0);
    check("clracc_streak", int'(stk8), 1);
    check("clracc_max", int'(max8), 8);

    // clr alone while holding: counters drop, result stays.
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_cnt_greater", int'(cg8), 0);
    check("clr_streak", int'(stk8), 0);
    check("clr_keeps_valid", int'(vld8), 1);
    check("clr_keeps_max", int'(max8), 8);

`ifndef CMP_ONEHOT_CHECK_EN
    // Priority decode: multiple flags and no flags.
    send(4'd4, 4'd4, 1, 1, 1, 0);
    check("prio_code", int'(code8), 2);
    send(4'd5, 4'd3, 0, 0, 0, 0);
    check("noflag_code", int'(code8), 0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 6);
      clr       = ($urandom_range(24) == 0);
      a = 4'($urandom); b = 4'($urandom);
      if ($urandom_range(7) == 0) begin
        lf = 1'($urandom); ef = 1'($urandom); gf = 1'($urandom);
      end else begin
        lf = (a < b); ef = (a == b); gf = (a > b);
      end
      step();
      if ($urandom_range(499) == 0) do_reset();
    end

    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
